instr_fetch_unit: RTL
=====================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the fetch address loaded on reset.
REQ-002 Parameter PC_STEP, default 4, SHALL be the sequential address increment in bytes.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 freeze  input  1  SHALL be the hazard stall: when 1, the output registers hold.
REQ-006 branch_taken  input  1  SHALL be a one-cycle redirect pulse.
REQ-007 branch_addr  input  32  SHALL be the redirect target, sampled when branch_taken=1.
REQ-008 imem_req_valid  output  1  SHALL indicate a fetch request is offered.
REQ-009 imem_req_addr  output  32  SHALL be the byte address of the offered request.
REQ-010 imem_req_ready  input  1  SHALL indicate the memory accepts the request this cycle.
REQ-011 imem_resp_valid  input  1  SHALL indicate imem_resp_data is valid this cycle.
REQ-012 imem_resp_data  input  32  SHALL be the returned instruction word.
REQ-013 if_valid  output  1  SHALL indicate instruction_out and pc_out hold a live instruction.
REQ-014 instruction_out  output  32  SHALL be the registered fetched instruction.
REQ-015 pc_out  output  32  SHALL be the registered fetch address plus PC_STEP.

Function
REQ-016 At most one request SHALL be outstanding; the FSM states are REQ, WAIT and HOLD.
REQ-017 REQ: imem_req_valid=1 unless branch_taken=1 this cycle (combinational gate); imem_req_addr=pc; handshake (valid and ready) -> WAIT, latching the address in req_pc.
REQ-018 WAIT: imem_req_valid=0; response latency is unbounded; no timeout.
REQ-019 WAIT, response, kill=0, freeze=0: instruction_out<=resp_data, pc_out<=req_pc+PC_STEP, if_valid<=1, pc<=req_pc+PC_STEP, -> REQ.
REQ-020 WAIT, response, kill=0, freeze=1: word and req_pc SHALL be stored in a one-entry hold buffer; pc<=req_pc+PC_STEP; -> HOLD.
REQ-021 HOLD: no request issued; when freeze=0 the buffer SHALL move to the output registers with if_valid<=1, -> REQ.
REQ-022 WAIT, response, kill=1: the word SHALL be discarded, kill<=0, -> REQ.
REQ-023 When freeze=0 and no word is transferred to the outputs that cycle, if_valid<=0 (bubble); instruction_out and pc_out retain their values.
REQ-024 When freeze=1, if_valid, instruction_out and pc_out SHALL hold.
REQ-025 branch_taken=1 SHALL take priority over freeze and over any response: pc<=branch_addr, if_valid<=0.
REQ-026 Branch in REQ: no request is issued that cycle; next cycle imem_req_addr=branch_addr.
REQ-027 Branch in WAIT without a same-cycle response: kill<=1, stay in WAIT; the later response is discarded.
REQ-028 Branch in WAIT with a same-cycle response: the word SHALL be discarded, -> REQ.
REQ-029 Branch in HOLD: the buffer SHALL be discarded, -> REQ.
REQ-030 Address arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
REQ-031 imem_resp_valid outside WAIT SHALL be ignored.

Reset
REQ-032 rst=1 SHALL have priority over all inputs and set pc=RESET_PC, state=REQ, kill=0, hold buffer empty, if_valid=0, instruction_out=0, pc_out=0.
REQ-033 Reset in WAIT or HOLD SHALL abandon the transaction; the instruction memory shares rst, so no late response is expected.
REQ-034 imem_req_valid SHALL be 0 while rst=1 and SHALL be 1 with imem_req_addr=RESET_PC in the first cycle after rst deasserts.

Verification
REQ-035 Zero-wait memory (ready=1, response the cycle after acceptance), words 0xE3A0_0001/0xE3A0_1002 -> if_valid=1 with pc_out=4, then pc_out=8; one bubble between instructions.
REQ-036 freeze=1 held 3 cycles while a response arrives -> outputs hold the prior instruction; the buffered word appears with pc_out=req_pc+4 the cycle after freeze drops; no refetch.
REQ-037 branch_taken=1, branch_addr=0x100 in WAIT, response 2 cycles later -> word discarded, next request address 0x100, first valid pc_out=0x104.
REQ-038 Branch concurrent with freeze=1 in HOLD -> buffer dropped, if_valid=0, next request at branch_addr.
REQ-039 Memory with ready=0 for 5 cycles -> imem_req_valid and imem_req_addr stable throughout; single acceptance.
REQ-040 RESET_PC=0xFFFF_FFFC -> first pc_out=0x0000_0000, next request address 0x0000_0000; rst asserted in WAIT -> request at RESET_PC the cycle after release.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding request fetcher with
// branch kill, one-entry hold buffer and registered IF outputs.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        if_valid,
    output logic [31:0] instruction_out,
    output logic [31:0] pc_out
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_e;

    localparam logic [31:0] STEP = 32'(PC_STEP);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        kill_q, kill_d;
    logic [31:0] hold_data_q, hold_data_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] next_pc;

    // Address of the word after the in-flight one, wraps modulo 2^32
    assign next_pc = req_pc_q + STEP;

    // Request is gated off by a same-cycle redirect and by reset
    assign imem_req_valid  = (state_q == S_REQ) && !branch_taken && !rst;
    assign imem_req_addr   = pc_q;
    assign if_valid        = if_valid_q;
    assign instruction_out = instr_q;
    assign pc_out          = pc_out_q;

    // Next-state: request handshake, response routing, redirect and stall
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        kill_d      = kill_q;
        hold_data_d = hold_data_q;
        instr_d     = instr_q;
        pc_out_d    = pc_out_q;
        if_valid_d  = freeze ? if_valid_q : 1'b0;
        unique case (state_q)
            S_REQ: begin
                if (branch_taken) begin
                    pc_d       = branch_addr;
                    if_valid_d = 1'b0;
                end else if (imem_req_ready) begin
                    req_pc_d = pc_q;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (branch_taken) begin
                    pc_d       = branch_addr;
                    if_valid_d = 1'b0;
                    if (imem_resp_valid) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (imem_resp_valid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else if (!freeze) begin
                        instr_d    = imem_resp_data;
                        pc_out_d   = next_pc;
                        if_valid_d = 1'b1;
                        pc_d       = next_pc;
                        state_d    = S_REQ;
                    end else begin
                        hold_data_d = imem_resp_data;
                        pc_d        = next_pc;
                        state_d     = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (branch_taken) begin
                    pc_d       = branch_addr;
                    if_valid_d = 1'b0;
                    state_d    = S_REQ;
                end else if (!freeze) begin
                    instr_d    = hold_data_q;
                    pc_out_d   = next_pc;
                    if_valid_d = 1'b1;
                    state_d    = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            req_pc_q    <= RESET_PC;
            kill_q      <= 1'b0;
            hold_data_q <= 32'h0;
            if_valid_q  <= 1'b0;
            instr_q     <= 32'h0;
            pc_out_q    <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            kill_q      <= kill_d;
            hold_data_q <= hold_data_d;
            if_valid_q  <= if_valid_d;
            instr_q     <= instr_d;
            pc_out_q    <= pc_out_d;
        end
    end

endmodule
